// File: rtl/cmos_stream_tx.sv
// CMOS-style href/vsync/RGB565 transmitter fed from a read FIFO, with programmable raster.
// Optional CMOS_TX_COLORBAR_EN: underflow fill pixels become 8 vertical colour bars instead of black.
module cmos_stream_tx #(
  parameter int H_ACTIVE = 1280,
  parameter int H_BLANK  = 200,
  parameter int V_ACTIVE = 720,
  parameter int VS_LINES = 4,
  parameter int V_BACK   = 16,
  parameter int V_FRONT  = 4
) (
  input  logic        cmos_pclk,
  input  logic        rst,
  input  logic        tx_en,
  output logic        fifo_rd_en,
  input  logic [15:0] fifo_rd_data,
  input  logic        fifo_empty,
  output logic        cmos_href,
  output logic        cmos_vsync,
  output logic [15:0] cmos_data,
  output logic        frame_busy,
  output logic        frame_done,
  output logic [15:0] underflow_cnt
);
  localparam int H_TOTAL = H_ACTIVE + H_BLANK;
  localparam int V_TOTAL = VS_LINES + V_BACK + V_ACTIVE + V_FRONT;
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VS   = VW'(VS_LINES);
  localparam logic [VW-1:0] V_A0   = VW'(VS_LINES + V_BACK);
  localparam logic [VW-1:0] V_A1   = VW'(VS_LINES + V_BACK + V_ACTIVE);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic [15:0]   uf_cnt_q, uf_cnt_d;
  logic [1:0]    act_pipe_q, act_pipe_d;
  logic [1:0]    vs_pipe_q, vs_pipe_d;
  logic          rd_d1_q, rd_d1_d;
  logic          need_d1_q, need_d1_d;
  logic [15:0]   data_q, data_d;
  logic [15:0]   fill_d1;

  logic run, frame_end, start, vs0, act0, need, uf;

  always_comb begin
    state_d   = state_q;
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    run       = (state_q == RUN);
    frame_end = run && (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);
    // A new frame begins either from IDLE or seamlessly after the last cycle.
    start     = tx_en && ((state_q == IDLE) || frame_end);
    case (state_q)
      IDLE: begin
        h_cnt_d = '0;
        v_cnt_d = '0;
        if (tx_en) state_d = RUN;
      end
      default: begin
        if (h_cnt_q == H_LAST) begin
          h_cnt_d = '0;
          if (v_cnt_q == V_LAST) begin
            v_cnt_d = '0;
            if (!tx_en) state_d = IDLE;
          end else begin
            v_cnt_d = v_cnt_q + 1'b1;
          end
        end else begin
          h_cnt_d = h_cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    vs0        = run && (v_cnt_q < V_VS);
    act0       = (v_cnt_q >= V_A0) && (v_cnt_q < V_A1) && (h_cnt_q < H_ACT);
    need       = run && act0;
    uf         = need && fifo_empty;
    fifo_rd_en = need && !fifo_empty;
    uf_cnt_d   = uf_cnt_q;
    if (start)
      uf_cnt_d = '0;
    else if (uf && (uf_cnt_q != 16'hFFFF))
      uf_cnt_d = uf_cnt_q + 16'd1;
    act_pipe_d = {act_pipe_q[0], need};
    vs_pipe_d  = {vs_pipe_q[0], vs0};
    rd_d1_d    = fifo_rd_en;
    need_d1_d  = need;
    // FIFO word arrives one cycle after the strobe; a missed read becomes a fill pixel.
    data_d     = rd_d1_q ? fifo_rd_data : (need_d1_q ? fill_d1 : 16'h0000);
  end

`ifdef CMOS_TX_COLORBAR_EN
  localparam int BAR_W = H_ACTIVE / 8;
  localparam int BPW   = $clog2(BAR_W + 1);
  localparam logic [BPW-1:0] BAR_LAST = BPW'(BAR_W - 1);

  logic [BPW-1:0] bar_pix_q, bar_pix_d;
  logic [2:0]     bar_idx_q, bar_idx_d;
  logic [15:0]    fill_q, fill_d;

  // Bar position tracks h_cnt without a divider; it restarts on every line start.
  always_comb begin
    bar_pix_d = bar_pix_q;
    bar_idx_d = bar_idx_q;
    if (h_cnt_d == '0) begin
      bar_pix_d = '0;
      bar_idx_d = '0;
    end else if (bar_pix_q == BAR_LAST) begin
      bar_pix_d = '0;
      bar_idx_d = bar_idx_q + 3'd1;
    end else begin
      bar_pix_d = bar_pix_q + 1'b1;
    end
    case (bar_idx_q)
      3'd0:    fill_d = 16'hFFFF;
      3'd1:    fill_d = 16'hFFE0;
      3'd2:    fill_d = 16'h07FF;
      3'd3:    fill_d = 16'h07E0;
      3'd4:    fill_d = 16'hF81F;
      3'd5:    fill_d = 16'hF800;
      3'd6:    fill_d = 16'h001F;
      default: fill_d = 16'h0000;
    endcase
  end

  always_ff @(posedge cmos_pclk or negedge rst) begin
    if (!rst) begin
      bar_pix_q <= '0;
      bar_idx_q <= '0;
      fill_q    <= '0;
    end else begin
      bar_pix_q <= bar_pix_d;
      bar_idx_q <= bar_idx_d;
      fill_q    <= fill_d;
    end
  end

  assign fill_d1 = fill_q;
`else
  assign fill_d1 = 16'h0000;
`endif

  always_ff @(posedge cmos_pclk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      h_cnt_q    <= '0;
      v_cnt_q    <= '0;
      uf_cnt_q   <= '0;
      act_pipe_q <= '0;
      vs_pipe_q  <= '0;
      rd_d1_q    <= 1'b0;
      need_d1_q  <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      h_cnt_q    <= h_cnt_d;
      v_cnt_q    <= v_cnt_d;
      uf_cnt_q   <= uf_cnt_d;
      act_pipe_q <= act_pipe_d;
      vs_pipe_q  <= vs_pipe_d;
      rd_d1_q    <= rd_d1_d;
      need_d1_q  <= need_d1_d;
      data_q     <= data_d;
    end
  end

  assign cmos_href     = act_pipe_q[1];
  assign cmos_vsync    = vs_pipe_q[1];
  assign cmos_data     = data_q;
  assign frame_busy    = run;
  assign frame_done    = frame_end;
  assign underflow_cnt = uf_cnt_q;
endmodule
